// File: rtl/md_pad_emu.sv
// md_pad_emu: device-side emulation of a Mega Drive 3/6-button pad.
// Follows the host select line, counts select pulses for the 6-button
// protocol and returns the count to 0 after a period with no select activity.
module md_pad_emu #(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned TIMEOUT_US = 1500,
  parameter bit          SIX_BTN    = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        select,
  input  logic [11:0] buttons,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase
);

  localparam int unsigned Div        = CLK_HZ / 1_000_000;
  localparam int unsigned PreW       = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);
  localparam logic [10:0] TimeoutVal = 11'(TIMEOUT_US);
  localparam logic [10:0] TimeoutPre = 11'(TIMEOUT_US - 1);

  logic            sync_q, sel_s, sel_d;
  logic [11:0]     btn_q;
  logic [PreW-1:0] presc_q, presc_d;
  logic [10:0]     timer_q, timer_d;
  logic [2:0]      phase_q, phase_d, phase_base;
  logic [5:0]      pad_q, pad_d, pressed;
  logic            fall, sel_edge, tick, timeout_hit;

  assign fall     = sel_d & ~sel_s;
  assign sel_edge = sel_d ^ sel_s;
  assign tick     = (presc_q == PreMax);

  // Select synchronizer plus one-cycle delay for edge detection; idle high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b1;
      sel_s  <= 1'b1;
      sel_d  <= 1'b1;
    end else begin
      sync_q <= select;
      sel_s  <= sync_q;
      sel_d  <= sel_s;
    end
  end

  // Prescaler restarts on every select edge so the timeout measures whole
  // microseconds from the last edge.
  always_comb begin
    presc_d = presc_q + PreW'(1);
    if (sel_edge || tick) presc_d = '0;
  end

  // Inactivity timer: clears on any edge, saturates at the timeout value.
  always_comb begin
    timer_d = timer_q;
    if (sel_edge) begin
      timer_d = '0;
    end else if ((timer_q != TimeoutVal) && tick) begin
      timer_d = timer_q + 11'd1;
    end
  end

  // Timeout counts as reached either while held at the limit or on the tick
  // that takes the timer there; it is applied before a coincident fall.
  assign timeout_hit = (timer_q == TimeoutVal) || (tick && (timer_q == TimeoutPre));

  // Phase next-state: timeout reset first, then saturating increment on fall.
  always_comb begin
    phase_base = timeout_hit ? 3'd0 : phase_q;
    phase_d    = phase_base;
    if (fall) phase_d = (phase_base >= 3'd4) ? 3'd4 : phase_base + 3'd1;
    if (!SIX_BTN) phase_d = 3'd0;
  end

  // Output mux in pressed-state {TR,TL,D3,D2,D1,D0}; uses the next phase so
  // the new phase and the new select level reach the pins together.
  always_comb begin
    pressed = '0;
    if (sel_s) begin
      if (phase_d == 3'd3) begin
        pressed = {btn_q[6], btn_q[5], btn_q[11], btn_q[7], btn_q[8], btn_q[9]};
      end else begin
        pressed = {btn_q[6], btn_q[5], btn_q[0], btn_q[1], btn_q[2], btn_q[3]};
      end
    end else begin
      case (phase_d)
        3'd3:    pressed = {btn_q[10], btn_q[4], 4'b1111};
        3'd4:    pressed = {btn_q[10], btn_q[4], 4'b0000};
        default: pressed = {btn_q[10], btn_q[4], 2'b11, btn_q[2], btn_q[3]};
      endcase
    end
    pad_d = ~pressed;
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_q   <= '0;
      presc_q <= '0;
      timer_q <= '0;
      phase_q <= '0;
      pad_q   <= 6'h3F;
    end else begin
      btn_q   <= buttons;
      presc_q <= presc_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      pad_q   <= pad_d;
    end
  end

  assign pad_out = pad_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_md_pad_emu.sv
// Bench for md_pad_emu: three instances (6-button at 4 MHz, 3-button, and a
// 1 MHz / short-timeout copy used to line a fall up with the timeout tick).
module tb_md_pad_emu;

  localparam int unsigned Us = 4;  // clk cycles per microsecond for u_main
  localparam int unsigned FastTo = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel_m, sel_3, sel_f;
  logic [11:0] btn_m, btn_3, btn_f;
  logic [5:0]  pad_m, pad_3, pad_f;
  logic [2:0]  ph_m, ph_3, ph_f;

  md_pad_emu #(.CLK_HZ(4_000_000), .TIMEOUT_US(1500), .SIX_BTN(1'b1)) u_main (
    .clk_sys(clk), .reset_n(rst_n), .select(sel_m), .buttons(btn_m),
    .pad_out(pad_m), .phase(ph_m)
  );
  md_pad_emu #(.CLK_HZ(4_000_000), .TIMEOUT_US(1500), .SIX_BTN(1'b0)) u_three (
    .clk_sys(clk), .reset_n(rst_n), .select(sel_3), .buttons(btn_3),
    .pad_out(pad_3), .phase(ph_3)
  );
  md_pad_emu #(.CLK_HZ(1_000_000), .TIMEOUT_US(FastTo), .SIX_BTN(1'b1)) u_fast (
    .clk_sys(clk), .reset_n(rst_n), .select(sel_f), .buttons(btn_f),
    .pad_out(pad_f), .phase(ph_f)
  );

  typedef struct {
    string      tag;
    logic [5:0] pad;
    logic [2:0] ph;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ph_model = 0;

  // Pin levels of a real pad: 0 on a pin = button pressed or ID driven low.
  function automatic logic [5:0] model_pad(input logic sel, input int ph,
                                           input logic [11:0] b);
    logic r, l, d, u, a, bb, c, x, y, z, st, md;
    logic p0, p1, p2, p3, ptl, ptr;
    r = b[0]; l = b[1]; d = b[2]; u = b[3]; a = b[4]; bb = b[5]; c = b[6];
    x = b[7]; y = b[8]; z = b[9]; st = b[10]; md = b[11];
    if (sel) begin
      ptr = c; ptl = bb;
      if (ph == 3) begin p3 = md; p2 = x; p1 = y; p0 = z; end
      else begin p3 = r; p2 = l; p1 = d; p0 = u; end
    end else begin
      ptr = st; ptl = a;
      if (ph == 3) begin p3 = 1; p2 = 1; p1 = 1; p0 = 1; end
      else if (ph == 4) begin p3 = 0; p2 = 0; p1 = 0; p0 = 0; end
      else begin p3 = 1; p2 = 1; p1 = d; p0 = u; end
    end
    return ~{ptr, ptl, p3, p2, p1, p0};
  endfunction

  // Drive main select, advance the phase model on a fall, queue the result.
  task automatic main_sel(input logic s, input string tag);
    if (sel_m && !s && ph_model < 4) ph_model++;
    sel_m = s;
    sb.push_back('{tag, model_pad(s, ph_model, btn_m), 3'(ph_model)});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel_m = 1'b1; sel_3 = 1'b1; sel_f = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ph_model = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_m = 12'hFFF;
    for (int i = 0; i < 6; i++) begin
      sel_m = i[0];
      sb.push_back('{"reset_hold", 6'h3F, 3'd0});
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (pad_m !== e.pad || ph_m !== e.ph) begin
        n_fail++;
        $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                 e.tag, pad_m, ph_m, e.pad, e.ph);
      end
    end
    sel_m = 1'b1;
    btn_m = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    ph_model = 0;
    sb.push_back('{"reset_release", 6'h3F, 3'd0});
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
  endtask

  task automatic test_button_read();
    logic [5:0] prev;
    btn_m = 12'h011;
    sb.push_back('{"btn_read_high", model_pad(1'b1, ph_model, 12'h011), 3'(ph_model)});
    @(negedge clk);
    n_checks++;
    if (pad_m !== 6'h3F) begin
      n_fail++;
      $display("FAIL btn_latency_early: pad_out=%b, required %b", pad_m, 6'h3F);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
    prev = e.pad;
    for (int i = 0; i < 2; i++) begin
      main_sel(i[0], i[0] ? "btn_read_high2" : "btn_read_low");
      repeat (2) @(negedge clk);
      n_checks++;
      if (pad_m !== prev) begin
        n_fail++;
        $display("FAIL sel_latency_early: pad_out=%b, required %b", pad_m, prev);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (pad_m !== e.pad || ph_m !== e.ph) begin
        n_fail++;
        $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                 e.tag, pad_m, ph_m, e.pad, e.ph);
      end
      prev = e.pad;
    end
  endtask

  task automatic test_six_button();
    apply_reset();
    btn_m = 12'h380;
    repeat (2) @(negedge clk);
    // L H L H L H L H L: phases 1,1,2,2,3,3,4,4,4
    for (int i = 0; i < 9; i++) begin
      main_sel(i[0], $sformatf("six_step%0d", i));
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (pad_m !== e.pad || ph_m !== e.ph) begin
        n_fail++;
        $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                 e.tag, pad_m, ph_m, e.pad, e.ph);
      end
      repeat (10 * Us - 3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.push_back('{"reset_async", 6'h3F, 3'd0});
    #1;
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
    sel_m = 1'b1;
    btn_m = 12'h000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ph_model = 0;
    repeat (3) @(negedge clk);
    main_sel(1'b0, "after_reset_low");
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    btn_m = 12'h000;
    for (int i = 0; i < 6; i++) begin
      main_sel(i[0], $sformatf("to_step%0d", i));
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (pad_m !== e.pad || ph_m !== e.ph) begin
        n_fail++;
        $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                 e.tag, pad_m, ph_m, e.pad, e.ph);
      end
      repeat (10 * Us - 3) @(negedge clk);
    end
    // Now high at phase 3; the rise above was the last edge.
    sb.push_back('{"to_1499us", 6'h3F, 3'd3});
    repeat (1499 * Us - 10 * Us) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
    ph_model = 0;
    sb.push_back('{"to_1501us", 6'h3F, 3'd0});
    repeat (2 * Us) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, e.pad, e.ph);
    end
    repeat (99 * Us) @(negedge clk);
    main_sel(1'b0, "to_next_low");
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_m !== e.pad || ph_m !== e.ph || e.pad !== 6'b110011) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_m, ph_m, 6'b110011, e.ph);
    end
  endtask

  task automatic test_six_off();
    int bad_seen = 0;
    btn_3 = 12'hB80;  // Mode, X, Y, Z
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sel_3 = i[0];
      sb.push_back('{$sformatf("three_step%0d", i), model_pad(i[0], 0, 12'hB80), 3'd0});
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (pad_3 === 6'b110000 || ph_3 !== 3'd0) bad_seen++;
        if (k == 3) begin
          e = sb.pop_front();
          n_checks++;
          if (pad_3 !== e.pad || ph_3 !== e.ph) begin
            n_fail++;
            $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                     e.tag, pad_3, ph_3, e.pad, e.ph);
          end
        end
      end
    end
    n_checks++;
    if (bad_seen !== 0) begin
      n_fail++;
      $display("FAIL three_no_id: bad cycles=%0d, required 0", bad_seen);
    end
  endtask

  task automatic test_timeout_fall();
    int fph = 0;
    btn_f = 12'h000;
    // Two quick pulses take the fast copy to phase 2, ending high.
    for (int i = 0; i < 4; i++) begin
      if (!i[0] && fph < 4) fph++;
      sel_f = i[0];
      sb.push_back('{$sformatf("fast_step%0d", i), model_pad(i[0], fph, 12'h000), 3'(fph)});
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (pad_f !== e.pad || ph_f !== e.ph) begin
        n_fail++;
        $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
                 e.tag, pad_f, ph_f, e.pad, e.ph);
      end
    end
    // The fall lands on the cycle the timer ticks from TIMEOUT_US-1 to the limit.
    repeat (FastTo - 3) @(negedge clk);
    sel_f = 1'b0;
    fph = 1;
    sb.push_back('{"coincide_fall", model_pad(1'b0, 1, 12'h000), 3'd1});
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_f !== e.pad || ph_f !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_f, ph_f, e.pad, e.ph);
    end
    // Timer cleared: phase survives a few more cycles, then times out.
    sb.push_back('{"coincide_timer_clear", model_pad(1'b0, 1, 12'h000), 3'd1});
    repeat (4) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_f !== e.pad || ph_f !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_f, ph_f, e.pad, e.ph);
    end
    sb.push_back('{"coincide_later_timeout", model_pad(1'b0, 0, 12'h000), 3'd0});
    repeat (FastTo + 4) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (pad_f !== e.pad || ph_f !== e.ph) begin
      n_fail++;
      $display("FAIL %s: pad_out=%b phase=%0d, required pad_out=%b phase=%0d",
               e.tag, pad_f, ph_f, e.pad, e.ph);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel_m = 1'b1; sel_3 = 1'b1; sel_f = 1'b1;
    btn_m = 12'h000; btn_3 = 12'h000; btn_f = 12'h000;
    @(negedge clk);
    test_reset();
    test_button_read();
    test_six_button();
    test_reset_mid();
    test_timeout();
    test_six_off();
    test_timeout_fall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
